// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: flash-side model of a quad fast-read device.
// Decodes opcode (1-bit), 24-bit address (4-bit), dummy clocks, then
// streams nibbles from an internal byte memory until chip select rises.
// Everything runs on s_pclk; SCK and CS are oversampled and edge-detected.
module qspi_flash_responder #(
    parameter int          MEM_ADDR_W   = 8,
    parameter int          DUMMY_CYCLES = 6,
    parameter logic [7:0]  READ_CMD     = 8'hEB
) (
    input  logic                  s_pclk,
    input  logic                  s_preset,
    input  logic                  qspi_ck_i,
    input  logic                  qspi_cs_i,
    input  logic [3:0]            qspi_io_i,
    output logic [3:0]            qspi_io_o,
    output logic [3:0]            qspi_io_t,
    input  logic                  mem_we,
    input  logic [MEM_ADDR_W-1:0] mem_waddr,
    input  logic [7:0]            mem_wdata,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    // Shift register only keeps what is ever looked at: 7 opcode bits, or
    // the address bits that survive truncation to MEM_ADDR_W.
    localparam int SH_W = (MEM_ADDR_W - 4 > 7) ? (MEM_ADDR_W - 4) : 7;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic [2:0]            state_reg;
    logic                  ck_q_reg;
    logic                  cs_q_reg;
    logic [7:0]            cnt_reg;
    logic [SH_W-1:0]       shift_reg;
    logic [MEM_ADDR_W-1:0] addr_reg;
    logic                  nib_sel_reg;   // 0: next fall fetches a new byte
    logic                  show_low_reg;  // 1: low nibble currently driven
    logic                  drive_reg;
    logic [7:0]            rd_byte_reg;
    logic [7:0]            mem [0:(2**MEM_ADDR_W)-1];

    logic sck_rise;
    logic sck_fall;
    logic rd_en;

    assign sck_rise = qspi_ck_i & ~ck_q_reg;
    assign sck_fall = ~qspi_ck_i & ck_q_reg;
    assign rd_en    = (state_reg == ST_DATA) & ~qspi_cs_i & sck_fall & ~nib_sel_reg;

    assign busy      = (state_reg != ST_IDLE);
    assign qspi_io_t = drive_reg ? 4'h0 : 4'hF;
    assign qspi_io_o = !drive_reg   ? 4'h0 :
                       show_low_reg ? rd_byte_reg[3:0] : rd_byte_reg[7:4];

    // Byte memory: backdoor write plus registered read on high-nibble fetch.
    // A write and a fetch to the same address in one cycle returns old data.
    always_ff @(posedge s_pclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_byte_reg <= mem[addr_reg];
        end
    end

    // Protocol FSM: command/address decode, dummy count, nibble streaming.
    always_ff @(posedge s_pclk) begin
        if (s_preset) begin
            state_reg    <= ST_IDLE;
            ck_q_reg     <= 1'b0;
            cs_q_reg     <= 1'b0;   // forces a fresh CS high->low before next command
            cnt_reg      <= '0;
            shift_reg    <= '0;
            addr_reg     <= '0;
            nib_sel_reg  <= 1'b0;
            show_low_reg <= 1'b0;
            drive_reg    <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            ck_q_reg <= qspi_ck_i;
            cs_q_reg <= qspi_cs_i;
            cmd_err  <= 1'b0;
            if (qspi_cs_i) begin
                // CS high wins over any SCK edge in the same cycle
                state_reg    <= ST_IDLE;
                cnt_reg      <= '0;
                shift_reg    <= '0;
                nib_sel_reg  <= 1'b0;
                show_low_reg <= 1'b0;
                drive_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_q_reg) begin
                            state_reg <= ST_CMD;
                            cnt_reg   <= '0;
                            shift_reg <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_reg <= {shift_reg[SH_W-2:0], qspi_io_i[0]};
                            if (cnt_reg == 8'd7) begin
                                cnt_reg <= '0;
                                if ({shift_reg[6:0], qspi_io_i[0]} == READ_CMD) begin
                                    state_reg <= ST_ADDR;
                                end else begin
                                    state_reg <= ST_IGNORE;
                                    cmd_err   <= 1'b1;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            shift_reg <= {shift_reg[SH_W-5:0], qspi_io_i};
                            if (cnt_reg == 8'd5) begin
                                cnt_reg   <= '0;
                                addr_reg  <= MEM_ADDR_W'({shift_reg, qspi_io_i});
                                state_reg <= ST_DUMMY;
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            if (cnt_reg == DUMMY_LAST) begin
                                cnt_reg     <= '0;
                                nib_sel_reg <= 1'b0;
                                state_reg   <= ST_DATA;
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall) begin
                            drive_reg <= 1'b1;
                            if (!nib_sel_reg) begin
                                nib_sel_reg  <= 1'b1;
                                show_low_reg <= 1'b0;
                            end else begin
                                nib_sel_reg  <= 1'b0;
                                show_low_reg <= 1'b1;
                                addr_reg     <= addr_reg + MEM_ADDR_W'(1);
                            end
                        end
                    end
                    ST_IGNORE: begin
                        drive_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: bit-bangs SCK/CS/IO at 4 s_pclk
// per SCK period and compares returned nibbles against hand-computed words.
module tb_qspi_flash_responder;

    logic       s_pclk = 1'b0;
    logic       s_preset;
    logic       qspi_ck_i;
    logic       qspi_cs_i;
    logic [3:0] qspi_io_i;
    logic [3:0] qspi_io_o;
    logic [3:0] qspi_io_t;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       cmd_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    qspi_flash_responder #(
        .MEM_ADDR_W(8),
        .DUMMY_CYCLES(6),
        .READ_CMD(8'hEB)
    ) dut (
        .s_pclk(s_pclk),
        .s_preset(s_preset),
        .qspi_ck_i(qspi_ck_i),
        .qspi_cs_i(qspi_cs_i),
        .qspi_io_i(qspi_io_i),
        .qspi_io_o(qspi_io_o),
        .qspi_io_t(qspi_io_t),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .cmd_err(cmd_err),
        .busy(busy)
    );

    always #5 s_pclk = ~s_pclk;

    // count cmd_err high cycles, sampled mid-period
    always @(negedge s_pclk) begin
        if (cmd_err) err_pulses = err_pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge s_pclk);
        #1;
    endtask

    // one SCK period: rise (DUT samples io), then fall; optional backdoor
    // write placed exactly in the cycle the fall is detected
    task automatic sck_pulse(input logic [3:0] io, input bit bd,
                             input logic [7:0] wa, input logic [7:0] wd);
        qspi_io_i = io;
        qspi_ck_i = 1'b1;
        tick(2);
        qspi_ck_i = 1'b0;
        if (bd) begin
            mem_we    = 1'b1;
            mem_waddr = wa;
            mem_wdata = wd;
        end
        tick(1);
        mem_we = 1'b0;
        tick(1);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr, input int n_addr);
        for (int i = 7; i >= 0; i--) sck_pulse({3'b000, cmd[i]}, 1'b0, 8'h00, 8'h00);
        for (int n = 5; n > 5 - n_addr; n--) sck_pulse(addr[n*4 +: 4], 1'b0, 8'h00, 8'h00);
    endtask

    // full 4-byte read transaction; returns data and io_t observations
    task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input bit bd,
                           output logic [31:0] data, output logic [3:0] t_pre,
                           output logic [3:0] t_dat);
        qspi_cs_i = 1'b0;
        tick(2);
        send_header(cmd, addr, 6);
        t_pre = 4'h0;
        for (int d = 0; d < 6; d++) begin
            if (d == 5) t_pre = qspi_io_t;
            sck_pulse(4'h0, bd && (d == 5), 8'h21, 8'h5A);
        end
        t_dat = 4'h0;
        for (int k = 0; k < 8; k++) begin
            data[31 - 4*k -: 4] = qspi_io_o;
            t_dat = t_dat | qspi_io_t;
            sck_pulse(4'h0, 1'b0, 8'h00, 8'h00);
        end
        qspi_cs_i = 1'b1;
        tick(2);
        $display("txn cmd=%02h addr=%06h data=%08h io_t_pre=%h io_t_data=%h", cmd, addr, data, t_pre, t_dat);
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            mem_we    = 1'b1;
            mem_waddr = 8'(i);
            mem_wdata = 8'(i);
            tick(1);
        end
        mem_we = 1'b0;
    endtask

    task automatic test_reset();
        s_preset = 1'b1; qspi_cs_i = 1'b1; qspi_ck_i = 1'b0; qspi_io_i = 4'h0;
        mem_we = 1'b0; mem_waddr = 8'h00; mem_wdata = 8'h00;
        tick(3);
        s_preset = 1'b0;
        tick(1);
        checks++; if (qspi_io_t !== 4'hF) begin errors++; $display("FAIL reset_io_t got=%h exp=F", qspi_io_t); end
        checks++; if (qspi_io_o !== 4'h0) begin errors++; $display("FAIL reset_io_o got=%h exp=0", qspi_io_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_basic_read();
        logic [31:0] d; logic [3:0] tp, td;
        do_read(8'hEB, 24'h00001C, 1'b0, d, tp, td);
        checks++; if (d !== 32'h1C1D1E1F) begin errors++; $display("FAIL basic_data got=%08h exp=1C1D1E1F", d); end
        checks++; if (tp !== 4'hF) begin errors++; $display("FAIL basic_io_t_dummy got=%h exp=F", tp); end
        checks++; if (td !== 4'h0) begin errors++; $display("FAIL basic_io_t_data got=%h exp=0", td); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        checks++; if (qspi_io_t !== 4'hF) begin errors++; $display("FAIL basic_io_t_after got=%h exp=F", qspi_io_t); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [3:0] tp, td;
        do_read(8'hEB, 24'h0000FE, 1'b0, d, tp, td);
        checks++; if (d !== 32'hFEFF0001) begin errors++; $display("FAIL wrap_data got=%08h exp=FEFF0001", d); end
        checks++; if (td !== 4'h0) begin errors++; $display("FAIL wrap_io_t got=%h exp=0", td); end
        do_read(8'hEB, 24'hAB12FE, 1'b0, d, tp, td);
        checks++; if (d !== 32'hFEFF0001) begin errors++; $display("FAIL wrap_upper_data got=%08h exp=FEFF0001", d); end
        checks++; if (td !== 4'h0) begin errors++; $display("FAIL wrap_upper_io_t got=%h exp=0", td); end
    endtask

    task automatic test_bad_opcode();
        logic [31:0] d; logic [3:0] tp, td;
        int base;
        base = err_pulses;
        do_read(8'h03, 24'h00001C, 1'b0, d, tp, td);
        checks++; if (err_pulses - base !== 1) begin errors++; $display("FAIL bad_cmd_err_pulses got=%0d exp=1", err_pulses - base); end
        checks++; if (td !== 4'hF) begin errors++; $display("FAIL bad_io_t_data got=%h exp=F", td); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_io_o got=%08h exp=00000000", d); end
        base = err_pulses;
        do_read(8'hEB, 24'h00001D, 1'b0, d, tp, td);
        checks++; if (d !== 32'h1D1E1F20) begin errors++; $display("FAIL bad_next_data got=%08h exp=1D1E1F20", d); end
        checks++; if (err_pulses - base !== 0) begin errors++; $display("FAIL bad_next_no_err got=%0d exp=0", err_pulses - base); end
    endtask

    task automatic test_cs_abort();
        logic [31:0] d; logic [3:0] tp, td;
        qspi_cs_i = 1'b0;
        tick(2);
        send_header(8'hEB, 24'hFFFFFF, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        qspi_cs_i = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (qspi_io_t !== 4'hF) begin errors++; $display("FAIL abort_io_t got=%h exp=F", qspi_io_t); end
        $display("txn cs_abort after 3 address nibbles busy=%b io_t=%h", busy, qspi_io_t);
        tick(2);
        do_read(8'hEB, 24'h000010, 1'b0, d, tp, td);
        checks++; if (d !== 32'h10111213) begin errors++; $display("FAIL abort_next_data got=%08h exp=10111213", d); end
    endtask

    task automatic test_reset_mid_data();
        logic [31:0] d; logic [3:0] tp, td; logic [3:0] nib;
        qspi_cs_i = 1'b0;
        tick(2);
        send_header(8'hEB, 24'h000040, 6);
        for (int i = 0; i < 6; i++) sck_pulse(4'h0, 1'b0, 8'h00, 8'h00);
        nib = qspi_io_o;
        checks++; if (nib !== 4'h4) begin errors++; $display("FAIL rst_mid_first_nib got=%h exp=4", nib); end
        checks++; if (qspi_io_t !== 4'h0) begin errors++; $display("FAIL rst_mid_io_t_pre got=%h exp=0", qspi_io_t); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_pre got=%b exp=1", busy); end
        s_preset = 1'b1;
        tick(1);
        s_preset = 1'b0;
        checks++; if (qspi_io_t !== 4'hF) begin errors++; $display("FAIL rst_mid_io_t got=%h exp=F", qspi_io_t); end
        checks++; if (qspi_io_o !== 4'h0) begin errors++; $display("FAIL rst_mid_io_o got=%h exp=0", qspi_io_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        td = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sck_pulse(4'h0, 1'b0, 8'h00, 8'h00);
            td = td & qspi_io_t;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_rest got=%b exp=0", busy); end
        checks++; if (td !== 4'hF) begin errors++; $display("FAIL rst_mid_io_t_rest got=%h exp=F", td); end
        $display("txn reset during data, remaining burst ignored");
        qspi_cs_i = 1'b1;
        tick(2);
        do_read(8'hEB, 24'h000030, 1'b0, d, tp, td);
        checks++; if (d !== 32'h30313233) begin errors++; $display("FAIL rst_mid_next_data got=%08h exp=30313233", d); end
    endtask

    task automatic test_backdoor_collision();
        logic [31:0] d; logic [3:0] tp, td;
        do_read(8'hEB, 24'h000021, 1'b1, d, tp, td);
        checks++; if (d !== 32'h21222324) begin errors++; $display("FAIL bd_same_cycle got=%08h exp=21222324", d); end
        do_read(8'hEB, 24'h000021, 1'b0, d, tp, td);
        checks++; if (d !== 32'h5A222324) begin errors++; $display("FAIL bd_repeat got=%08h exp=5A222324", d); end
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_read();
        test_wrap();
        test_bad_opcode();
        test_cs_abort();
        test_reset_mid_data();
        test_backdoor_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
